mini_core_lsu_sb: RTL
=====================

// Module: mini_core_lsu_sb
// PURPOSE
//  Parametrised load/store buffer between the mini_core Q103H memory-access stage and D_MEM.
//  Stores are posted into a SB_DEPTH-entry in-order store buffer and drained in the background.
//  Loads bypass the buffer, or forward from the youngest matching store (store-to-load forwarding).
//  Back-pressure to the pipe is a single ready signal; load data returns in Q104H.
// PARAMETERS
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2)
//  ADDR_W    32  byte-address width
//  DATA_W    32  data width; BE_W = DATA_W/8 byte enables; word index = Addr[ADDR_W-1:log2(BE_W)]
// PORTS
//  Clock         in   1       core clock
//  Rst           in   1       asynchronous reset, active-high
//  ReqValidQ103H in   1       core request valid
//  ReqWrEnQ103H  in   1       1=store (exclusive with ReqRdEnQ103H)
//  ReqRdEnQ103H  in   1       1=load
//  ReqAddrQ103H  in   ADDR_W  byte address
//  ReqDataQ103H  in   DATA_W  store data, byte lanes pre-aligned
//  ReqBeQ103H    in   BE_W    byte enables
//  ReqReady      out  1       request accepted this cycle when ReqValid && ReqReady
//  RspValidQ104H out  1       load data valid
//  RspDataQ104H  out  DATA_W  load data (raw word; sign-ext is done in WB)
//  MemReqValid   out  1       D_MEM request valid
//  MemWrEn       out  1       D_MEM write
//  MemRdEn       out  1       D_MEM read
//  MemAddr       out  ADDR_W  D_MEM address
//  MemWrData     out  DATA_W  D_MEM write data
//  MemBe         out  BE_W    D_MEM byte enables
//  MemReady      in   1       D_MEM accepts request this cycle
//  MemRdRsp      in   DATA_W  D_MEM read data, exactly 1 cycle after accepted read
//  SbEmpty       out  1       store buffer empty (fence/CSR use)
// BEHAVIOUR
//  Reset: buffer empty, rd/wr ptr=0, count=0; ReqReady=1 (comb. from empty state), RspValidQ104H=0,
//   RspDataQ104H=0, MemReqValid=0, SbEmpty=1. Reset mid-drain discards all entries; no write issued.
//  Store buffer: circular FIFO, ptrs wrap SB_DEPTH-1 -> 0, count 0..SB_DEPTH.
//   Store accepted iff count<SB_DEPTH; full blocks a store even if a drain dequeues same cycle.
//   Enqueue at wr_ptr on accept; visible to forwarding from the next cycle.
//  Load match: valid entry with equal word index and (entry.Be & ReqBe)!=0; consider youngest match only.
//   Forward hit: youngest match has (entry.Be & ReqBe)==ReqBe -> ReqReady=1, no D_MEM access,
//    RspValidQ104H=1 next cycle, RspDataQ104H=entry data.
//   Partial hit: youngest match does not cover ReqBe -> ReqReady=0; drain continues until no
//    partial match, then re-evaluate.
//   No match: load issued to D_MEM same cycle (MemRdEn=1); ReqReady=MemReady;
//    RspValidQ104H=1 one cycle after acceptance with RspDataQ104H=MemRdRsp.
//  D_MEM arbitration (one request/cycle): pending non-forwarded load wins; otherwise head entry
//   drains (MemWrEn=1) when count>0; rd_ptr advances on MemReady. Loads never reorder past
//   overlapping stores; non-overlapping loads may pass older stores.
//  Simultaneous store enqueue + drain dequeue: count unchanged, both ptrs advance.
//  Non-load/store or !ReqValid cycles: ReqReady=1 unless a partial hit is pending; RspValidQ104H=0.
//  SbEmpty = (count==0) registered-state based, no combinational path from Req*.
//  Latency: load 1 cycle (forward or D_MEM); store posted 0 cycles, drains >=1 cycle after enqueue.
// TESTING
//  T1 store 0x100 data 0xAABBCCDD BE=F, MemReady=1 -> ReqReady=1; next cycle MemWrEn addr 0x100; SbEmpty=1 after.
//  T2 MemReady=0, 4 stores then 5th -> 5th ReqReady=0; count=4; release MemReady -> drains in order 0..3, ptr wraps.
//  T3 store 0x200=0x11223344 BE=F, load 0x200 BE=1 while MemReady=0 -> RspValidQ104H=1, data 0x11223344, no MemRdEn.
//  T4 store 0x300 BE=3, load 0x300 BE=F -> ReqReady=0 until store drains, then MemRdEn addr 0x300, rsp from MemRdRsp.
//  T5 2 stores pending, load 0x400 (no match) -> load issued first, stores drain after; rsp 1 cycle after accept.
//  T6 assert Rst with count=3 mid-drain -> SbEmpty=1, MemReqValid=0 immediately; no further writes.

Source files
------------

// File: rtl/mini_core_lsu_sb_if.sv
// rtl/mini_core_lsu_sb_if.sv - core-side and D_MEM-side bundles for the load/store buffer

// Core pipe request (Q103H) and load response (Q104H).
interface mini_core_lsu_sb_core_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              ReqValidQ103H;
  logic              ReqWrEnQ103H;
  logic              ReqRdEnQ103H;
  logic [ADDR_W-1:0] ReqAddrQ103H;
  logic [DATA_W-1:0] ReqDataQ103H;
  logic [BE_W-1:0]   ReqBeQ103H;
  logic              ReqReady;
  logic              RspValidQ104H;
  logic [DATA_W-1:0] RspDataQ104H;

  modport master (
    output ReqValidQ103H, ReqWrEnQ103H, ReqRdEnQ103H, ReqAddrQ103H, ReqDataQ103H, ReqBeQ103H,
    input  ReqReady, RspValidQ104H, RspDataQ104H
  );

  modport slave (
    input  ReqValidQ103H, ReqWrEnQ103H, ReqRdEnQ103H, ReqAddrQ103H, ReqDataQ103H, ReqBeQ103H,
    output ReqReady, RspValidQ104H, RspDataQ104H
  );
endinterface

// D_MEM request channel with its one-cycle read return.
interface mini_core_lsu_sb_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              MemReqValid;
  logic              MemWrEn;
  logic              MemRdEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic [BE_W-1:0]   MemBe;
  logic              MemReady;
  logic [DATA_W-1:0] MemRdRsp;

  modport master (
    output MemReqValid, MemWrEn, MemRdEn, MemAddr, MemWrData, MemBe,
    input  MemReady, MemRdRsp
  );

  modport slave (
    input  MemReqValid, MemWrEn, MemRdEn, MemAddr, MemWrData, MemBe,
    output MemReady, MemRdRsp
  );
endinterface

// File: rtl/mini_core_lsu_sb.sv
// rtl/mini_core_lsu_sb.sv - posted store buffer with store-to-load forwarding in front of D_MEM

module mini_core_lsu_sb #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                    Clock,
  input  logic                    Rst,
  mini_core_lsu_sb_core_if.slave  core,
  mini_core_lsu_sb_mem_if.master  mem,
  output logic                    SbEmpty
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry payload; occupancy is tracked purely by pointers and count.
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [BE_W-1:0]   sb_be_q   [SB_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              fwd_valid_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic              rd_pend_q;

  logic              is_load, is_store, sb_full;
  logic              hit_found, hit_full;
  logic [PTR_W-1:0]  hit_idx, scan_idx;
  logic              fwd, partial, ld_mem, drain, enq, deq;

  assign is_load  = core.ReqValidQ103H & core.ReqRdEnQ103H;
  assign is_store = core.ReqValidQ103H & core.ReqWrEnQ103H;
  assign sb_full  = (count_q == CNT_W'(SB_DEPTH));

  // Scan oldest to youngest so the last overlapping entry seen is the youngest match.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (sb_addr_q[scan_idx][ADDR_W-1:OFF] == core.ReqAddrQ103H[ADDR_W-1:OFF]) &&
          (|(sb_be_q[scan_idx] & core.ReqBeQ103H))) begin
        hit_found = 1'b1;
        hit_idx   = scan_idx;
      end
    end
  end

  assign hit_full = ((sb_be_q[hit_idx] & core.ReqBeQ103H) == core.ReqBeQ103H);
  assign fwd      = is_load & hit_found & hit_full;
  assign partial  = is_load & hit_found & ~hit_full;
  assign ld_mem   = is_load & ~hit_found;

  // A non-matching load owns D_MEM this cycle; otherwise the head entry drains.
  assign drain = ~ld_mem & (count_q != '0);
  assign enq   = is_store & ~sb_full;
  assign deq   = drain & mem.MemReady;

  // Stores see only the pre-cycle occupancy, so a same-cycle drain never frees a slot early.
  always_comb begin
    core.ReqReady = 1'b1;
    if (is_store)     core.ReqReady = ~sb_full;
    else if (partial) core.ReqReady = 1'b0;
    else if (ld_mem)  core.ReqReady = mem.MemReady;
  end

  assign mem.MemReqValid = ld_mem | drain;
  assign mem.MemRdEn     = ld_mem;
  assign mem.MemWrEn     = drain;
  assign mem.MemAddr     = ld_mem ? core.ReqAddrQ103H : sb_addr_q[rd_ptr_q];
  assign mem.MemBe       = ld_mem ? core.ReqBeQ103H   : sb_be_q[rd_ptr_q];
  assign mem.MemWrData   = drain  ? sb_data_q[rd_ptr_q] : '0;

  // D_MEM data arrives in the response cycle itself, so it is passed straight through.
  assign core.RspValidQ104H = fwd_valid_q | rd_pend_q;
  assign core.RspDataQ104H  = rd_pend_q ? mem.MemRdRsp : fwd_data_q;
  assign SbEmpty            = (count_q == '0);

  assign wr_ptr_d = wr_ptr_q + PTR_W'(enq);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(deq);
  assign count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);

  // Queue control and load-response state; reset discards every buffered store.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fwd_valid_q <= fwd;
      if (fwd) fwd_data_q <= sb_data_q[hit_idx];
      rd_pend_q   <= ld_mem & mem.MemReady;
    end
  end

  // Entry payload write; contents are only meaningful while counted as occupied.
  always_ff @(posedge Clock) begin
    if (enq) begin
      sb_addr_q[wr_ptr_q] <= core.ReqAddrQ103H;
      sb_data_q[wr_ptr_q] <= core.ReqDataQ103H;
      sb_be_q[wr_ptr_q]   <= core.ReqBeQ103H;
    end
  end
endmodule
